data_mem_responder: RTL and testbench

Data-memory responder for the RV32IM pipeline's MEM stage. Accepts load/store requests and asserts busy_wait for a fixed multi-cycle latency, which stalls the pipeline registers. It performs byte/half/word accesses with RV32 load sign/zero extension and returns load data for capture into the MEM/WB register.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 64 ++++++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes, FSM states,
// and the default access latency.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DMEM_DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte/half/word lane steering: load extraction with sign/zero extension,
// store merge into the old word, and the misalignment flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] raw_word,
  input  logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        store_en,
  output logic        misalign
);

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  // Halves always come from the even half selected by addr_lo[1], which aligns odd addresses down.
  always_comb begin
    ld_byte = raw_word[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    case (funct3)
      F3_B:    load_data = 32'(ld_byte);
      F3_H:    load_data = 32'(ld_half);
      F3_BU:   load_data = {24'h000000, ld_byte};
      F3_HU:   load_data = {16'h0000, ld_half};
      default: load_data = raw_word;
    endcase
  end

  always_comb begin
    store_word = raw_word;
    store_en   = 1'b0;
    case (funct3)
      F3_B: begin
        store_word[{addr_lo, 3'b000} +: 8] = write_data[7:0];
        store_en = 1'b1;
      end
      F3_H: begin
        store_word[{addr_lo[1], 4'b0000} +: 16] = write_data[15:0];
        store_en = 1'b1;
      end
      F3_W: begin
        store_word = write_data;
        store_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // lhu has no store counterpart, so 101 only flags on the load path.
  always_comb begin
    misalign = 1'b0;
    case (funct3)
      F3_H:    misalign = addr_lo[0];
      F3_HU:   misalign = addr_lo[0] & ~is_store;
      F3_W:    misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory with fixed LATENCY stall via busy_wait. Optional macro
// DMEM_MISALIGN_TRAP_EN adds the misaligned output and suppresses misaligned accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = DMEM_DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy_wait
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  dmem_state_e           state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  req;
  logic                  do_access;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [31:0]           wdata_q;
  logic                  is_write_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           raw_word;
  logic [31:0]           load_word;
  logic [31:0]           store_word;
  logic                  store_en;
  logic                  lane_misalign;
  logic                  access_ok;
  logic                  unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign idx_q            = addr_q[ADDR_WIDTH+1:2];
  assign raw_word         = mem[idx_q];
  assign unused_addr_bits = ^address[31:ADDR_WIDTH+2];

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The request cycle plus LATENCY-1 ACCESS cycles gives exactly LATENCY busy cycles.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    busy_wait = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          busy_wait = 1'b1;
          state_n   = ACCESS;
          cnt_n     = CNT_W'(LATENCY - 2);
        end
      end
      ACCESS: begin
        busy_wait = 1'b1;
        if (cnt == '0) begin
          do_access = 1'b1;
          state_n   = DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request capture; read wins when both strobes are high
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_q     <= address[ADDR_WIDTH+1:0];
      funct3_q   <= funct3;
      wdata_q    <= write_data;
      is_write_q <= mem_write & ~mem_read;
    end
  end

  dmem_lane_align u_lane_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .is_store   (is_write_q),
    .raw_word   (raw_word),
    .write_data (wdata_q),
    .load_data  (load_word),
    .store_word (store_word),
    .store_en   (store_en),
    .misalign   (lane_misalign)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign access_ok = ~lane_misalign;

  always_ff @(posedge clk) begin
    if (reset) misaligned <= 1'b0;
    else       misaligned <= do_access & lane_misalign;
  end
`else
  logic unused_misalign;
  assign access_ok       = 1'b1;
  assign unused_misalign = lane_misalign;
`endif

  // Access completion on the ACCESS->DONE edge; a reset on that edge discards the store
  always_ff @(posedge clk) begin
    if (!reset && do_access && is_write_q && store_en && access_ok)
      mem[idx_q] <= store_word;
  end

  always_ff @(posedge clk) begin
    if (reset)
      read_data <= '0;
    else if (do_access && !is_write_q)
      read_data <= access_ok ? load_word : 32'h0;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, hand-written
// stall/reset sequences, and randomized traffic against a word-array reference model.
module tb_data_mem_responder;

  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 4;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        busy_wait;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busy_wait  (busy_wait)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain word array indexed by byte address / 4, modulo depth.
  logic [31:0] mdl [0:(2**ADDR_WIDTH)-1];

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % (2**ADDR_WIDTH);
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a, input bit st);
    int unsigned lane = a % 4;
    if (f3 == 3'd1 || (f3 == 3'd5 && !st)) return (lane % 2) == 1;
    if (f3 == 3'd2) return lane != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b, h;
    int unsigned lane;
    w = mdl[widx(a)];
    lane = a % 4;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, mask, val;
    int unsigned lane;
    w = mdl[widx(a)];
    lane = a % 4;
    case (f3)
      3'd0: begin mask = 32'hFF << (8 * lane); val = (wd & 32'hFF) << (8 * lane); end
      3'd1: begin mask = 32'hFFFF << (16 * (lane / 2)); val = (wd & 32'hFFFF) << (16 * (lane / 2)); end
      3'd2: begin mask = 32'hFFFFFFFF; val = wd; end
      default: begin mask = 32'h0; val = 32'h0; end
    endcase
    mdl[widx(a)] = (w & ~mask) | (val & mask);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One full transaction: request at a negedge, count busy cycles, check outputs in DONE.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_mis, input string name);
    int n;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; address = a; write_data = wd;
    #1;
    n = 0;
    while (busy_wait === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, ":busy"}, 32'(n), 32'(LATENCY));
    chk({name, ":rdata"}, read_data, exp_rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk({name, ":mis"}, 32'(misaligned), 32'(exp_mis));
`endif
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int n, r;
    logic rd, wr, st, mis;
    logic [2:0] f3;
    logic [31:0] a, wd, model_rd;

    vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0013, 32'h000000A5, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hA5ADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0013, 32'h0,        32'hFFFFFFA5, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0013, 32'h0,        32'h000000A5, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0012, 32'h00008001, 32'h000000A5, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0012, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0012, 32'h0,        32'h00008001, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'h8001BEEF, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'd2, 32'h0000_1010, 32'hCAFEF00D, 32'h8001BEEF, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'h00000000, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 3'd3, 32'h0000_0010, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hCAFEF00D, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[16] = '{1'b1, 1'b0, 3'd2, 32'h0000_0011, 32'h0,        32'h00000000, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 3'd1, 32'h0000_0013, 32'h0,        32'h00000000, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 3'd1, 32'h0000_0011, 32'h00001234, 32'h00000000, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hCAFEF00D, 1'b0};
`else
    vecs[16] = '{1'b1, 1'b0, 3'd2, 32'h0000_0011, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd1, 32'h0000_0013, 32'h0,        32'hFFFFCAFE, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 3'd1, 32'h0000_0011, 32'h00001234, 32'hFFFFCAFE, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hCAFE1234, 1'b0};
`endif

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; address = 32'h0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset:rdata", read_data, 32'h0);
    chk("reset:busy", 32'(busy_wait), 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("reset:mis", 32'(misaligned), 32'h0);
`endif

    for (int i = 0; i < 20; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd,
          vecs[i].exp, vecs[i].mis, $sformatf("vec%0d", i));
`ifdef DMEM_MISALIGN_TRAP_EN
      @(negedge clk);
      chk($sformatf("vec%0d:mis_after", i), 32'(misaligned), 32'h0);
`endif
    end

    // Load held through DONE: exactly one access, then idle
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'd2; address = 32'h10;
    #1;
    n = 0;
    while (busy_wait === 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("hold:busy", 32'(n), 32'(LATENCY));
    chk("hold:rdata", read_data, vecs[19].exp);
    chk("hold:done_busy", 32'(busy_wait), 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    #1;
    chk("hold:idle_busy", 32'(busy_wait), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold:quiet%0d", k), 32'(busy_wait), 32'h0);
    end
    txn(1'b0, 1'b1, 3'd2, 32'h24, 32'h0BADF00D, vecs[19].exp, 1'b0, "b2b_sw");
    txn(1'b1, 1'b0, 3'd2, 32'h24, 32'h0,        32'h0BADF00D, 1'b0, "b2b_lw");

    // Request dropped during ACCESS still completes on latched values
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'd2; address = 32'h30; write_data = 32'h5A5A1234;
    #1;
    n = 0;
    while (busy_wait === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      mem_write = 1'b0;
      #1;
    end
    chk("drop:busy", 32'(n), 32'(LATENCY));
    txn(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, 32'h5A5A1234, 1'b0, "drop_lw");

    // Reset on the final ACCESS cycle discards the store and clears read_data
    txn(1'b0, 1'b1, 3'd2, 32'h20, 32'h11111111, 32'h5A5A1234, 1'b0, "rst_sw1");
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'd2; address = 32'h20; write_data = 32'h12345678;
    repeat (3) @(negedge clk);
    reset = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    chk("rst:busy", 32'(busy_wait), 32'h0);
    chk("rst:rdata", read_data, 32'h0);
    reset = 1'b0;
    txn(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h11111111, 1'b0, "rst_lw");

    // Randomized traffic over a pre-initialized 16-word window, with address aliasing
    model_rd = 32'h11111111;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      a  = 32'h100 + 32'(4 * i);
      ref_store(3'd2, a, wd);
      txn(1'b0, 1'b1, 3'd2, a, wd, model_rd, 1'b0, $sformatf("init%0d", i));
    end
    for (int i = 0; i < 150; i++) begin
      r  = int'($urandom_range(0, 3));
      rd = (r != 1);
      wr = (r == 1) || (r == 2);
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12);
      wd = $urandom;
      st = wr & ~rd;
      mis = MIS_EN && ref_mis(f3, a, st);
      if (!st) model_rd = mis ? 32'h0 : ref_load(f3, a);
      else if (!mis) ref_store(f3, a, wd);
      txn(rd, wr, f3, a, wd, model_rd, mis, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
